// File: rtl/fg_pkg.sv
// Shared types and node-word layout for the ForestGuard decision-tree engines.
package fg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DECIDE,
        OUT
    } state_t;

    localparam logic [3:0]  LEAF_FID = 4'hF;
    localparam int unsigned FID_W    = 4;

    // Node word, MSB->LSB: {th, fid, lc, rc, cls}
    localparam int unsigned CLS_LSB  = 0;

    function automatic int unsigned node_w(input int unsigned feat_w,
                                           input int unsigned addr_w,
                                           input int unsigned cls_w);
        return feat_w + FID_W + 2 * addr_w + cls_w;
    endfunction

    function automatic int unsigned rc_lsb(input int unsigned cls_w);
        return CLS_LSB + cls_w;
    endfunction

    function automatic int unsigned lc_lsb(input int unsigned addr_w,
                                           input int unsigned cls_w);
        return rc_lsb(cls_w) + addr_w;
    endfunction

    function automatic int unsigned fid_lsb(input int unsigned addr_w,
                                            input int unsigned cls_w);
        return lc_lsb(addr_w, cls_w) + addr_w;
    endfunction

    function automatic int unsigned th_lsb(input int unsigned addr_w,
                                           input int unsigned cls_w);
        return fid_lsb(addr_w, cls_w) + FID_W;
    endfunction

endpackage

// File: rtl/dt_node_rom.sv
// Node ROM with a one-cycle registered read; contents are placed by the enclosing environment.
module dt_node_rom #(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 36,
    parameter string       ROM_FILE = ""
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        data <= mem[addr];
    end

endmodule

// File: rtl/dt_engine.sv
// Single-tree decision-tree walker: accepts a feature vector, walks the node ROM
// to a leaf (with depth watchdog and illegal-feature abort) and returns the class.
module dt_engine
    import fg_pkg::*;
#(
    parameter int unsigned NUM_FEAT  = 8,
    parameter int unsigned FEAT_W    = 12,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned CLS_W     = 2,
    parameter int unsigned MAX_DEPTH = 32,
    parameter int unsigned BASE      = 0,
    parameter string       ROM_FILE  = ""
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_FEAT*FEAT_W-1:0]    in_feat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CLS_W-1:0]              out_class,
    output logic                          out_err,
    output logic [$clog2(MAX_DEPTH+1)-1:0] out_depth
);

    localparam int unsigned NODE_W  = node_w(FEAT_W, ADDR_W, CLS_W);
    localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int unsigned RC_LSB  = rc_lsb(CLS_W);
    localparam int unsigned LC_LSB  = lc_lsb(ADDR_W, CLS_W);
    localparam int unsigned FID_LSB = fid_lsb(ADDR_W, CLS_W);
    localparam int unsigned TH_LSB  = th_lsb(ADDR_W, CLS_W);

    state_t              state, state_d;
    logic [FEAT_W-1:0]   feat_q [NUM_FEAT];
    logic                feat_load;
    logic [ADDR_W-1:0]   node_q, node_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                in_ready_d, out_valid_d, out_err_d;
    logic [CLS_W-1:0]    out_class_d;
    logic [DEPTH_W-1:0]  out_depth_d;

    logic [ADDR_W-1:0]   rom_addr;
    logic [NODE_W-1:0]   rom_data;
    logic [FEAT_W-1:0]   node_th;
    logic [FID_W-1:0]    node_fid;
    logic [ADDR_W-1:0]   node_lc, node_rc;
    logic [CLS_W-1:0]    node_cls;
    logic [FEAT_W-1:0]   feat_sel;

    // Tree offset wraps inside the shared ROM image
    assign rom_addr = ADDR_W'(BASE) + node_q;

    dt_node_rom #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (NODE_W),
        .ROM_FILE (ROM_FILE)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    assign node_th  = rom_data[TH_LSB  +: FEAT_W];
    assign node_fid = rom_data[FID_LSB +: FID_W];
    assign node_lc  = rom_data[LC_LSB  +: ADDR_W];
    assign node_rc  = rom_data[RC_LSB  +: ADDR_W];
    assign node_cls = rom_data[CLS_LSB +: CLS_W];

    always_comb begin
        feat_sel = '0;
        for (int k = 0; k < NUM_FEAT; k++) begin
            if (node_fid == FID_W'(k)) feat_sel = feat_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d     = state;
        feat_load   = 1'b0;
        node_d      = node_q;
        depth_d     = depth_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        out_class_d = out_class;
        out_err_d   = out_err;
        out_depth_d = out_depth;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    feat_load  = 1'b1;
                    node_d     = '0;
                    depth_d    = '0;
                    in_ready_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            FETCH: state_d = DECIDE;
            DECIDE: begin
                out_depth_d = depth_q;
                if (node_fid == LEAF_FID) begin
                    out_class_d = node_cls;
                    out_err_d   = 1'b0;
                    state_d     = OUT;
                end else if ((32'(node_fid) >= NUM_FEAT) ||
                             (depth_q == DEPTH_W'(MAX_DEPTH))) begin
                    out_class_d = '0;
                    out_err_d   = 1'b1;
                    state_d     = OUT;
                end else begin
                    node_d  = (feat_sel <= node_th) ? node_lc : node_rc;
                    depth_d = depth_q + DEPTH_W'(1);
                    state_d = FETCH;
                end
            end
            OUT: begin
                // Result registers settle one cycle before out_valid is raised
                if (!out_valid) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            node_q    <= '0;
            depth_q   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_class <= '0;
            out_err   <= 1'b0;
            out_depth <= '0;
            for (int k = 0; k < NUM_FEAT; k++) feat_q[k] <= '0;
        end else begin
            node_q    <= node_d;
            depth_q   <= depth_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_class <= out_class_d;
            out_err   <= out_err_d;
            out_depth <= out_depth_d;
            if (feat_load) begin
                for (int k = 0; k < NUM_FEAT; k++) feat_q[k] <= in_feat[k*FEAT_W +: FEAT_W];
            end
        end
    end

endmodule

// File: tb/tb_dt_engine.sv
// Directed bench for dt_engine: three engines over the same test tree at BASE 0, 5 and 6.
module tb_dt_engine;

    localparam int NF = 8;
    localparam int FW = 12;

    logic           clk;
    logic           rst;
    logic [NF*FW-1:0] feat;
    logic           in_valid_s  [3];
    logic           in_ready_s  [3];
    logic           out_valid_s [3];
    logic           out_ready_s [3];
    logic [1:0]     out_class_s [3];
    logic           out_err_s   [3];
    logic [5:0]     out_depth_s [3];

    int checks = 0;
    int errors = 0;

    dt_engine #(.BASE(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .in_feat(feat), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .out_class(out_class_s[0]), .out_err(out_err_s[0]), .out_depth(out_depth_s[0]));

    dt_engine #(.BASE(5)) u5 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .in_feat(feat), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .out_class(out_class_s[1]), .out_err(out_err_s[1]), .out_depth(out_depth_s[1]));

    dt_engine #(.BASE(6)) u6 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .in_feat(feat), .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
        .out_class(out_class_s[2]), .out_err(out_err_s[2]), .out_depth(out_depth_s[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [35:0] nd(input int th, input int fid, input int lc,
                                       input int rc, input int cls);
        return {12'(th), 4'(fid), 9'(lc), 9'(rc), 2'(cls)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int w, input int f0, input int f3);
        int n = 0;
        while (!in_ready_s[w] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready_s[w]) chk("send_in_ready_timeout", 0, 1);
        feat = '0;
        feat[0*FW +: FW] = 12'(f0);
        feat[3*FW +: FW] = 12'(f3);
        in_valid_s[w] = 1'b1;
        @(posedge clk); #1;
        in_valid_s[w] = 1'b0;
        feat = '1;
    endtask

    task automatic wait_out(input int w, output int lat);
        lat = 0;
        while (!out_valid_s[w] && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid_s[w]) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic pop(input int w);
        out_ready_s[w] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[w] = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        int f0;
        int f3;
        int cls;
        int err;
        int depth;
        int lat;
    } vec_t;

    initial begin
        vec_t vecs [6];
        logic [35:0] img [7];
        int lat;
        int bad;

        rst  = 1'b0;
        feat = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid_s[i]  = 1'b0;
            out_ready_s[i] = 1'b0;
        end

        img[0] = nd(100, 0, 1, 2, 0);
        img[1] = nd(0, 15, 0, 0, 1);
        img[2] = nd(7, 3, 3, 4, 0);
        img[3] = nd(0, 15, 0, 0, 2);
        img[4] = nd(0, 15, 0, 0, 3);
        img[5] = nd(0, 0, 5, 5, 0);
        img[6] = nd(0, 9, 0, 0, 0);
        for (int a = 0; a < 512; a++) begin
            u0.u_rom.mem[a] = '0;
            u5.u_rom.mem[a] = '0;
            u6.u_rom.mem[a] = '0;
        end
        for (int a = 0; a < 7; a++) begin
            u0.u_rom.mem[a] = img[a];
            u5.u_rom.mem[a] = img[a];
            u6.u_rom.mem[a] = img[a];
        end

        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready",  int'(in_ready_s[0]),  1);
        chk("rst_out_valid", int'(out_valid_s[0]), 0);
        chk("rst_out_class", int'(out_class_s[0]), 0);
        chk("rst_out_err",   int'(out_err_s[0]),   0);
        chk("rst_out_depth", int'(out_depth_s[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        vecs[0] = '{f0: 100,  f3: 0,    cls: 1, err: 0, depth: 1, lat: 5};
        vecs[1] = '{f0: 101,  f3: 8,    cls: 3, err: 0, depth: 2, lat: 7};
        vecs[2] = '{f0: 0,    f3: 4095, cls: 1, err: 0, depth: 1, lat: 5};
        vecs[3] = '{f0: 4095, f3: 7,    cls: 2, err: 0, depth: 2, lat: 7};
        vecs[4] = '{f0: 101,  f3: 0,    cls: 2, err: 0, depth: 2, lat: 7};
        vecs[5] = '{f0: 4095, f3: 4095, cls: 3, err: 0, depth: 2, lat: 7};

        for (int i = 0; i < 6; i++) begin
            send(0, vecs[i].f0, vecs[i].f3);
            wait_out(0, lat);
            chk($sformatf("vec%0d_class", i), int'(out_class_s[0]), vecs[i].cls);
            chk($sformatf("vec%0d_err", i),   int'(out_err_s[0]),   vecs[i].err);
            chk($sformatf("vec%0d_depth", i), int'(out_depth_s[0]), vecs[i].depth);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            pop(0);
            chk($sformatf("vec%0d_in_ready_after_pop", i), int'(in_ready_s[0]), 1);
            chk($sformatf("vec%0d_valid_after_pop", i), int'(out_valid_s[0]), 0);
        end

        // Backpressure: result held for 10 cycles
        send(0, 101, 8);
        wait_out(0, lat);
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!out_valid_s[0] || out_class_s[0] != 2'd3 || out_err_s[0] ||
                out_depth_s[0] != 6'd2 || in_ready_s[0]) bad++;
        end
        chk("hold_stable_bad_cycles", bad, 0);
        pop(0);
        chk("hold_release_in_ready", int'(in_ready_s[0]), 1);
        chk("hold_release_valid",    int'(out_valid_s[0]), 0);
        send(0, 50, 0);
        wait_out(0, lat);
        chk("after_hold_class",   int'(out_class_s[0]), 1);
        chk("after_hold_latency", lat, 5);
        pop(0);

        // Self-loop tree: watchdog must abort at MAX_DEPTH
        send(1, 3, 3);
        wait_out(1, lat);
        chk("loop_err",     int'(out_err_s[1]),   1);
        chk("loop_class",   int'(out_class_s[1]), 0);
        chk("loop_depth",   int'(out_depth_s[1]), 32);
        chk("loop_latency", lat, 67);
        pop(1);

        // Illegal feature id at the root
        send(2, 3, 3);
        wait_out(2, lat);
        chk("badfid_err",     int'(out_err_s[2]),   1);
        chk("badfid_class",   int'(out_class_s[2]), 0);
        chk("badfid_depth",   int'(out_depth_s[2]), 0);
        chk("badfid_latency", lat, 3);
        pop(2);

        // Reset during FETCH of a 2-level walk (previous result had class 1)
        send(0, 101, 8);
        chk("pre_rst_in_ready_low", int'(in_ready_s[0]), 0);
        rst = 1'b1;
        #1;
        chk("midwalk_rst_in_ready",  int'(in_ready_s[0]),  1);
        chk("midwalk_rst_out_valid", int'(out_valid_s[0]), 0);
        chk("midwalk_rst_out_class", int'(out_class_s[0]), 0);
        chk("midwalk_rst_out_depth", int'(out_depth_s[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midwalk_no_spurious_valid", int'(out_valid_s[0]), 0);
        send(0, 101, 0);
        wait_out(0, lat);
        chk("post_rst_class",   int'(out_class_s[0]), 2);
        chk("post_rst_depth",   int'(out_depth_s[0]), 2);
        chk("post_rst_latency", lat, 7);

        // Reset while a result is pending in OUT discards it
        rst = 1'b1;
        #1;
        chk("out_rst_out_valid", int'(out_valid_s[0]), 0);
        chk("out_rst_in_ready",  int'(in_ready_s[0]),  1);
        chk("out_rst_out_class", int'(out_class_s[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, 4095, 4095);
        wait_out(0, lat);
        chk("final_class", int'(out_class_s[0]), 3);
        chk("final_err",   int'(out_err_s[0]),   0);
        pop(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
